// File: rtl/rr_arbiter_encoder8_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_encoder8_pkg
// Shared constants for the round-robin arbiter / register-code encoder:
//   CODE_W   - width of the encoded register field (XXX/YYY)
//   ONEHOT_W - width of the one-hot request/grant vectors
//   CNT_W    - width of the hold counter (MAXHOLD up to 255)
//   ST_IDLE / ST_HOLD - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package rr_arbiter_encoder8_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;
  localparam int CNT_W    = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage : rr_arbiter_encoder8_pkg

// File: rtl/rr_arbiter_encoder8_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_encoder8_if
// Request/grant bundle between the requesters and the arbiter.
//   Req[7:0]   requester -> arbiter  Req[7-i] requests register code i
//   En         requester -> arbiter  permits new grants
//   Done       requester -> arbiter  current holder releases the grant
//   Grant[7:0] arbiter -> requester  one-hot grant, same bit order as Req
//   Code[2:0]  arbiter -> requester  encoded register field of the holder
//   Valid      arbiter -> requester  Grant/Code identify a current holder
//   Expired    arbiter -> requester  one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_encoder8_if;
  import rr_arbiter_encoder8_pkg::*;

  logic [ONEHOT_W-1:0] Req;
  logic                En;
  logic                Done;
  logic [ONEHOT_W-1:0] Grant;
  logic [CODE_W-1:0]   Code;
  logic                Valid;
  logic                Expired;

  modport master (
    output Req, En, Done,
    input  Grant, Code, Valid, Expired
  );

  modport slave (
    input  Req, En, Done,
    output Grant, Code, Valid, Expired
  );

endinterface : rr_arbiter_encoder8_if

// File: rtl/rr_arbiter_encoder8_pick.sv
// ---------------------------------------------------------------------------
// decode3_8bits
// 3-to-8 decoder in the arbiter's bit order: code i drives o_onehot[7-i].
//   i_en      enable; all outputs 0 when low
//   i_code    3-bit register code
//   o_onehot  one-hot result
//
// rr_pick8
// Combinational round-robin search: first requesting code found scanning
// i_ptr, i_ptr+1, ... (mod 8).
//   i_req     request vector (Req[7-i] = code i)
//   i_ptr     code where the search starts
//   o_code    winning code (0 when nothing requests)
//   o_any     at least one request present
//   o_onehot  winner as one-hot, same bit order as i_req
// ---------------------------------------------------------------------------
module decode3_8bits
  import rr_arbiter_encoder8_pkg::*;
(
  input  logic                i_en,
  input  logic [CODE_W-1:0]   i_code,
  output logic [ONEHOT_W-1:0] o_onehot
);

  // For a 3-bit code, 7-i equals the bitwise inverse of i.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    o_onehot = '0;
    if (i_en) o_onehot[~i_code] = 1'b1;
  end

endmodule : decode3_8bits

module rr_pick8
  import rr_arbiter_encoder8_pkg::*;
(
  input  logic [ONEHOT_W-1:0] i_req,
  input  logic [CODE_W-1:0]   i_ptr,
  output logic [CODE_W-1:0]   o_code,
  output logic                o_any,
  output logic [ONEHOT_W-1:0] o_onehot
);

  logic [CODE_W-1:0] w_cand;

  // Scan from the farthest offset down to offset 0 so the candidate nearest
  // to i_ptr is the last one written and therefore wins; no early exit needed.
  always_comb begin
    o_code = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = ONEHOT_W - 1; k >= 0; k--) begin
      w_cand = i_ptr + CODE_W'(k);
      if (i_req[~w_cand]) begin
        o_code = w_cand;
        o_any  = 1'b1;
      end
    end
  end

  decode3_8bits u_decode (
    .i_en     (1'b1),
    .i_code   (o_code),
    .o_onehot (o_onehot)
  );

endmodule : rr_pick8

// File: rtl/rr_arbiter_encoder8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_encoder8
// Round-robin arbiter over 8 request lines that also emits the 3-bit register
// code of the winner. A grant is held until the holder signals Done, drops its
// request, or MAXHOLD cycles elapse (forced release, flagged by Expired).
// Every grant is separated from the next by at least one idle cycle.
//   Clock   rising-edge clock
//   Resetn  asynchronous active-low reset
//   bus     rr_arbiter_encoder8_if.slave (Req/En/Done in, Grant/Code/Valid/
//           Expired out, all registered outputs)
// Parameter MAXHOLD: maximum grant length in cycles (2..255).
// ---------------------------------------------------------------------------
module rr_arbiter_encoder8
  import rr_arbiter_encoder8_pkg::*;
#(
  parameter int MAXHOLD = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  rr_arbiter_encoder8_if.slave bus
);

  logic [0:0]          r_state;
  logic [CODE_W-1:0]   r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [ONEHOT_W-1:0] r_grant;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic                r_expired;

  logic [CODE_W-1:0]   w_pick_code;
  logic                w_pick_any;
  logic [ONEHOT_W-1:0] w_pick_onehot;
  logic                w_held_req;
  logic                w_cnt_max;
  logic                w_release;
  logic                w_forced;

  rr_pick8 u_pick (
    .i_req    (bus.Req),
    .i_ptr    (r_ptr),
    .o_code   (w_pick_code),
    .o_any    (w_pick_any),
    .o_onehot (w_pick_onehot)
  );

  // r_grant is zero outside HOLD, so this only looks at the holder's line.
  assign w_held_req = |(bus.Req & r_grant);
  assign w_cnt_max  = (r_cnt == CNT_W'(MAXHOLD - 1));
  assign w_release  = bus.Done | ~w_held_req | w_cnt_max;
  // Done or a dropped request take precedence over the counter.
  assign w_forced   = w_cnt_max & ~bus.Done & w_held_req;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_expired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.En && w_pick_any) begin
            r_state <= ST_HOLD;
            r_grant <= w_pick_onehot;
            r_code  <= w_pick_code;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (w_release) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= r_code + CODE_W'(1);
            r_expired <= w_forced;
          end else if (!w_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Grant   = r_grant;
  assign bus.Code    = r_code;
  assign bus.Valid   = r_valid;
  assign bus.Expired = r_expired;

endmodule : rr_arbiter_encoder8

// File: tb/tb_rr_arbiter_encoder8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_encoder8
// Self-checking bench for rr_arbiter_encoder8 (MAXHOLD=4). A behavioural model
// is stepped on every rising edge; its expected outputs go into a scoreboard
// queue and are popped and compared on the following falling edge. Directed
// checks on top of that pin down the scenario-specific values.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_encoder8;

  localparam int MAXHOLD = 4;

  typedef struct packed {
    logic       expired;
    logic       valid;
    logic [2:0] code;
    logic [7:0] grant;
  } out_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;

  rr_arbiter_encoder8_if bus_if ();

  rr_arbiter_encoder8 #(.MAXHOLD(MAXHOLD)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_if.slave)
  );

  always #5 Clock = ~Clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t sb_q[$];
  out_t obs;

  // Reference model state
  bit m_hold;
  int m_ptr;
  int m_cnt;
  int m_code;
  bit m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.expired = bus_if.Expired;
    o.valid   = bus_if.Valid;
    o.code    = bus_if.Code;
    o.grant   = bus_if.Grant;
    return o;
  endfunction

  task automatic model_reset();
    m_hold = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_code = 0;
    m_exp  = 0;
    sb_q.delete();
  endtask

  task automatic model_step();
    bit held;
    bit maxed;
    if (!m_hold) begin
      m_exp = 0;
      if (bus_if.En && bus_if.Req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (bus_if.Req[7-c]) begin
            m_code = c;
            m_hold = 1;
            m_cnt  = 0;
            break;
          end
        end
      end
    end else begin
      held  = bus_if.Req[7-m_code];
      maxed = (m_cnt == MAXHOLD - 1);
      if (bus_if.Done || !held || maxed) begin
        m_exp  = maxed && !bus_if.Done && held;
        m_hold = 0;
        m_ptr  = (m_code + 1) % 8;
      end else begin
        m_exp = 0;
        m_cnt++;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    o.expired = m_exp;
    o.valid   = m_hold;
    o.code    = m_hold ? 3'(m_code) : 3'd0;
    o.grant   = m_hold ? (8'h80 >> m_code) : 8'h00;
    return o;
  endfunction

  // One clock: model sees the same inputs as the DUT at the edge, the result
  // is compared half a cycle later.
  task automatic tick();
    out_t e;
    @(posedge Clock);
    model_step();
    sb_q.push_back(model_out());
    @(negedge Clock);
    e   = sb_q.pop_front();
    obs = dut_out();
    check("cycle", obs, e);
  endtask

  // Asserts reset away from any clock edge, checks outputs cleared at once,
  // then releases it on a falling edge.
  task automatic apply_reset(input string tag);
    Resetn = 1'b0;
    #1;
    check(tag, dut_out(), '0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int n_valid;
    bus_if.Req  = 8'h00;
    bus_if.En   = 1'b0;
    bus_if.Done = 1'b0;
    model_reset();

    #2;
    apply_reset("reset_state");

    // No requests with En high: stays idle with all outputs 0
    bus_if.En = 1'b1;
    tick();
    tick();
    check("idle_zero", obs, '0);

    // Single request on code 000, Done release, pointer moves to 1
    bus_if.Req = 8'h80;
    tick();
    check("basic_code", obs.code, 3'd0);
    check("basic_grant", obs.grant, 8'h80);
    check("basic_valid", obs.valid, 1'b1);
    bus_if.Done = 1'b1;
    tick();
    check("basic_release", obs.valid, 1'b0);
    bus_if.Done = 1'b0;
    bus_if.Req  = 8'hFF;
    tick();
    check("ptr_after_done", obs.code, 3'd1);
    bus_if.Req = 8'h00;
    tick();
    tick();

    // Alternation between code 000 and 111 from Ptr=0
    apply_reset("reset_mid");
    bus_if.En  = 1'b1;
    bus_if.Req = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("alt_code", obs.code, (i == 1) ? 3'd7 : 3'd0);
      check("alt_valid", obs.valid, 1'b1);
      bus_if.Done = 1'b1;
      tick();
      check("alt_gap", obs.valid, 1'b0);
      bus_if.Done = 1'b0;
    end
    bus_if.Req = 8'h00;
    tick();

    // Forced release after MAXHOLD cycles, then re-grant after one idle cycle
    bus_if.Req = 8'h08;
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs.valid) n_valid++;
    end
    check("maxhold_len", n_valid, MAXHOLD);
    check("maxhold_expired", obs.expired, 1'b1);
    tick();
    check("maxhold_regrant", {obs.valid, obs.code}, {1'b1, 3'd4});
    bus_if.Req = 8'h00;
    tick();
    tick();

    // Grant stable against En=0 and other Req bits, released by dropping Req[5]
    bus_if.Req = 8'h20;
    tick();
    check("stable_code", obs.code, 3'd2);
    bus_if.En  = 1'b0;
    bus_if.Req = 8'hA1;
    tick();
    check("stable_grant1", obs.grant, 8'h20);
    bus_if.Req = 8'h2C;
    tick();
    check("stable_grant2", obs.grant, 8'h20);
    bus_if.Req = 8'h0C;
    tick();
    check("drop_release", {obs.valid, obs.expired}, 2'b00);
    tick();
    tick();
    check("en_low_nogrant", obs.valid, 1'b0);
    bus_if.En = 1'b1;
    tick();
    check("en_low_ptr_kept", obs.code, 3'd4);
    bus_if.Req = 8'h00;
    tick();
    tick();

    // Done coincides with counter expiry on code 111; pointer wraps to 000
    bus_if.Req = 8'h01;
    tick();
    check("wrap_code", obs.code, 3'd7);
    tick();
    tick();
    tick();
    bus_if.Done = 1'b1;
    tick();
    check("done_at_max", {obs.valid, obs.expired}, 2'b00);
    bus_if.Done = 1'b0;
    bus_if.Req  = 8'hFF;
    tick();
    check("ptr_wrap", obs.code, 3'd0);
    bus_if.Req = 8'h00;
    tick();
    tick();

    // Move Ptr to 6, then reset mid-HOLD on code 101 and search from 000
    bus_if.Req = 8'h04;
    tick();
    check("pre_reset_code", obs.code, 3'd5);
    bus_if.Req = 8'h00;
    tick();
    tick();
    bus_if.Req = 8'h04;
    tick();
    check("hold_before_reset", obs.code, 3'd5);
    #2;
    apply_reset("async_reset");
    bus_if.Req = 8'h05;
    tick();
    check("search_from_zero", obs.code, 3'd5);
    bus_if.Req = 8'h00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter_encoder8

// File: doc/rr_arbiter_encoder8.md
RR_ARBITER_ENCODER8 -- requirements
Module: rr_arbiter_encoder8

Interface
REQ-001 SHALL have parameter MAXHOLD, default 16: the maximum number of cycles a grant is held before forced release (range 2..255).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Req, input, 8 bits: one-hot-style request lines; Req[7-i] is the request for register code i (Req[7] is code 000, Req[0] is code 111).
REQ-005 SHALL have port En, input, 1 bit: high permits new grants.
REQ-006 SHALL have port Done, input, 1 bit: the current holder releases the grant.
REQ-007 SHALL have port Grant, output, 8 bits: one-hot grant using the same bit order as Req; all zero when idle.
REQ-008 SHALL have port Code, output, 3 bits: the encoded register field (XXX/YYY format) of the granted line.
REQ-009 SHALL have port Valid, output, 1 bit: high while Grant/Code identify a current holder.
REQ-010 SHALL have port Expired, output, 1 bit: a one-cycle pulse on a forced (MAXHOLD) release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-012 IDLE -> HOLD SHALL occur when En=1 and any Req bit is 1; Grant, Code and Valid SHALL be registered and appear on the next edge (latency 1 cycle).
REQ-013 SHALL select the winner round-robin: search codes Ptr, Ptr+1, ... mod 8 and take the first requesting code.
REQ-014 SHALL encode the winner so that Code=i and Grant=Req bit [7-i], with exactly one Grant bit set in HOLD.
REQ-015 SHALL keep Grant and Code stable for the whole of HOLD, regardless of Req changes on other lines or of En.
REQ-016 HOLD -> IDLE SHALL occur on the first of the following: Done=1; the granted Req bit is 0; or the hold counter reaches MAXHOLD-1.
REQ-017 Valid SHALL be 0 for at least one IDLE cycle between consecutive grants, and Grant SHALL be 0 in IDLE.
REQ-018 On release, Ptr SHALL become (granted code + 1) mod 8; wrap-around from 7 SHALL go to 0.
REQ-019 The hold counter SHALL clear on entry to HOLD and increment each HOLD cycle, saturating at MAXHOLD-1.
REQ-020 Expired SHALL pulse for the release cycle only when release is caused by the counter and neither Done nor a dropped request.
REQ-021 When Done and counter expiry coincide, SHALL release with Expired=0.
REQ-022 When En=0 in IDLE, SHALL make no grant and leave Ptr unchanged.
REQ-023 When all Req bits are 0 in IDLE, SHALL remain in IDLE with all outputs 0.

Reset
REQ-024 Resetn=0 SHALL immediately force: state IDLE, Ptr=0, counter=0, Grant=8'b0, Code=3'b000, Valid=0, Expired=0.
REQ-025 Reset asserted mid-HOLD SHALL drop the grant asynchronously; after release, the first grant SHALL search from code 000.

Structure
REQ-026 The state encoding (IDLE, HOLD) and the code/one-hot width constants (3, 8) SHALL live in the shared processor package.
REQ-027 The round-robin search plus index-to-one-hot SHALL be one combinational sub-module, rr_pick8 (inputs Req and Ptr; outputs winner code and any flag). The one-hot output SHALL reuse decode3_8bits with En=1.

Verification
REQ-028 Reset, Req=8'b1000_0000, En=1 -> next cycle Code=000, Grant=8'b1000_0000, Valid=1; Done=1 -> next cycle Valid=0, Ptr=1.
REQ-029 Ptr=0, Req=8'b1000_0001 held, Done pulsed per grant -> grants alternate Code 000, 111, 000 with one idle cycle between.
REQ-030 MAXHOLD=4, Req=8'b0000_1000 held, Done=0 -> Valid high exactly 4 cycles with Code=100, Expired=1 in the release cycle, then a re-grant after one idle cycle.
REQ-031 In HOLD with Code=010, set En=0 and toggle other Req bits -> Grant stays 8'b0010_0000; dropping Req[5] -> release, Expired=0.
REQ-032 Resetn pulled low mid-HOLD with Code=101 -> outputs 0 without waiting for a clock edge; after release with Req=8'b0000_0101 -> Code=101 granted (search from 000).
REQ-033 Done and counter expiry in the same cycle -> release with Expired=0; Ptr=code+1 wrapping 111->000.
